serial_port: RTL and testbench

//  Byte-wide write port -> TX FIFO -> internal UART-style serializer -> 1-bit loopback line
//  -> deserializer -> RX FIFO -> byte-wide read port. Flow control via full/empty flags.

---
 rtl/serial_port.sv | 180 ++++++++++++++++++
 tb/tb_serial_port.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_port.sv
// serial_port: byte write port -> TX FIFO -> serializer -> 1-bit loopback line
// -> deserializer -> RX FIFO -> byte read port.
// A frame only starts when the RX side is guaranteed room for it, so no byte
// is ever lost on the link.
// All FIFO ports and both FSMs share one clock and a synchronous active-high reset.
module serial_port #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_e,
  input  logic             r_e,
  input  logic [WIDTH-1:0] input_data,
  output logic [WIDTH-1:0] output_data,
  output logic             e_f,
  output logic             f_f
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;
  typedef enum logic [1:0] {D_IDLE, D_DATA, D_STOP} des_state_t;

  // TX FIFO
  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    tx_wr, tx_rd;
  logic [AW:0]      tx_count;
  // RX FIFO
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    rx_wr, rx_rd;
  logic [AW:0]      rx_count;
  // Serializer
  ser_state_t       s_state;
  logic [WIDTH-1:0] tx_sh;
  logic [BW-1:0]    s_cnt;
  logic             line;
  // Deserializer
  des_state_t       d_state;
  logic [WIDTH-1:0] rx_sh;
  logic [BW-1:0]    d_cnt;
  logic             in_flight;

  logic tx_push, tx_pop, rx_push, rx_pop;
  logic rx_ready, ser_can_load, start_ok;

  // Handshake: tx_pop is the "valid & ready" moment. valid = TX FIFO non-empty,
  // ready = serializer free (IDLE or finishing STOP) and RX has room counting
  // the frame already on the line. Both must hold at the same edge.
  assign e_f          = (rx_count == '0);
  assign f_f          = (tx_count == FULL_CNT);
  assign tx_push      = w_e & ~f_f;
  assign rx_pop       = r_e & ~e_f;
  assign rx_push      = (d_state == D_STOP) & line;
  assign rx_ready     = (rx_count + {{AW{1'b0}}, in_flight}) < FULL_CNT;
  assign ser_can_load = (s_state == S_IDLE) || (s_state == S_STOP);
  assign start_ok     = ser_can_load && (tx_count != '0) && rx_ready;
  assign tx_pop       = start_ok;

  // TX FIFO storage (no reset needed; validity is tracked by the count)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= input_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_sh;
  end

  // RX FIFO pointers, occupancy and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr       <= '0;
      rx_rd       <= '0;
      rx_count    <= '0;
      output_data <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop) begin
        rx_rd       <= rx_rd + 1'b1;
        output_data <= rx_mem[rx_rd];
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Serializer: start bit, WIDTH data bits LSB first, stop bit; back-to-back frames from STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state <= S_IDLE;
      tx_sh   <= '0;
      s_cnt   <= '0;
      line    <= 1'b1;
    end else begin
      case (s_state)
        S_START: begin
          line    <= tx_sh[0];
          tx_sh   <= {1'b0, tx_sh[WIDTH-1:1]};
          s_cnt   <= '0;
          s_state <= S_DATA;
        end
        S_DATA: begin
          if (s_cnt == LAST_BIT) begin
            line    <= 1'b1;
            s_state <= S_STOP;
          end else begin
            line  <= tx_sh[0];
            tx_sh <= {1'b0, tx_sh[WIDTH-1:1]};
            s_cnt <= s_cnt + 1'b1;
          end
        end
        default: begin  // S_IDLE and S_STOP can both launch a new frame
          if (start_ok) begin
            tx_sh   <= tx_mem[tx_rd];
            line    <= 1'b0;
            s_state <= S_START;
          end else begin
            line    <= 1'b1;
            s_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Deserializer plus in-flight flag; a new launch wins over the clear of the previous frame
  always_ff @(posedge clk) begin
    if (rst) begin
      d_state   <= D_IDLE;
      rx_sh     <= '0;
      d_cnt     <= '0;
      in_flight <= 1'b0;
    end else begin
      if (start_ok)                  in_flight <= 1'b1;
      else if (d_state == D_STOP)    in_flight <= 1'b0;
      case (d_state)
        D_IDLE: begin
          if (!line) begin
            d_cnt   <= '0;
            d_state <= D_DATA;
          end
        end
        D_DATA: begin
          rx_sh <= {line, rx_sh[WIDTH-1:1]};
          if (d_cnt == LAST_BIT) d_state <= D_STOP;
          else                   d_cnt   <= d_cnt + 1'b1;
        end
        default: begin
          // Good stop bit pushes rx_sh (rx_push); a bad one just drops the byte.
          d_state <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// Bench for serial_port: a per-cycle vector table for reset / single-byte latency,
// then hand-written sequences for burst, full, concurrent and mid-frame reset.
module tb_serial_port;

  logic       clk;
  logic       rst;
  logic       w_e;
  logic       r_e;
  logic [7:0] input_data;
  logic [7:0] output_data;
  logic       e_f;
  logic       f_f;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  bit use_sb = 0;

  typedef struct {
    logic       w_e;
    logic       r_e;
    logic [7:0] din;
    logic       exp_e_f;
    logic       exp_f_f;
    logic [7:0] exp_out;
  } vec_t;
  vec_t vecs[15];

  serial_port #(.DEPTH(8), .WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .w_e         (w_e),
    .r_e         (r_e),
    .input_data  (input_data),
    .output_data (output_data),
    .e_f         (e_f),
    .f_f         (f_f)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // One clock: inputs are set at the negedge, the edge happens, outputs are
  // sampled at the next negedge. The scoreboard checks every read that occurred.
  task automatic tick();
    bit pend;
    pend = use_sb && r_e && !e_f;
    @(posedge clk);
    @(negedge clk);
    if (pend) begin
      if (exp_q.size() == 0) flag_fail("read_unexpected");
      else check("read_data", {24'd0, output_data}, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; w_e = 1'b0; r_e = 1'b0; input_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit expect_accept);
    w_e = 1'b1;
    input_data = b;
    if (expect_accept) exp_q.push_back(b);
    tick();
    w_e = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    r_e = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    r_e = 1'b0;
    if (exp_q.size() != 0) flag_fail(name);
  endtask

  initial begin
    rst = 1'b1; w_e = 1'b0; r_e = 1'b0; input_data = 8'h00;
    @(negedge clk);

    // ---- Test 1: reset state ----
    do_reset();
    check("rst_e_f", {31'd0, e_f}, 32'd1);
    check("rst_f_f", {31'd0, f_f}, 32'd0);
    check("rst_out", {24'd0, output_data}, 32'h00);

    // ---- Tests 1+2: per-cycle table (empty read, single byte latency) ----
    for (int i = 0; i < 15; i++)
      vecs[i] = '{w_e: 1'b0, r_e: 1'b0, din: 8'h00, exp_e_f: 1'b1, exp_f_f: 1'b0, exp_out: 8'h00};
    vecs[0].r_e  = 1'b1;                         // read while empty: ignored
    vecs[1].w_e  = 1'b1; vecs[1].din = 8'h68;    // write at edge k
    vecs[12].exp_e_f = 1'b0;                     // visible after edge k+11
    vecs[13].r_e = 1'b1; vecs[13].exp_out = 8'h68;
    vecs[14].r_e = 1'b1; vecs[14].exp_out = 8'h68; // empty again: output holds
    use_sb = 0;
    for (int i = 0; i < 15; i++) begin
      w_e = vecs[i].w_e;
      r_e = vecs[i].r_e;
      input_data = vecs[i].din;
      tick();
      check($sformatf("vec%0d_e_f", i), {31'd0, e_f}, {31'd0, vecs[i].exp_e_f});
      check($sformatf("vec%0d_f_f", i), {31'd0, f_f}, {31'd0, vecs[i].exp_f_f});
      check($sformatf("vec%0d_out", i), {24'd0, output_data}, {24'd0, vecs[i].exp_out});
    end
    w_e = 1'b0; r_e = 1'b0;

    // ---- Test 3: burst with RX backpressure ----
    use_sb = 1;
    do_reset();
    begin
      logic [7:0] msg [9];
      msg = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72};
      for (int i = 0; i < 9; i++) write_byte(msg[i], 1'b1);
    end
    for (int i = 0; i < 100; i++) tick();
    check("burst_e_f", {31'd0, e_f}, 32'd0);
    check("burst_f_f", {31'd0, f_f}, 32'd0);
    drain(300, "burst_drain_timeout");
    tick();
    check("burst_empty_after", {31'd0, e_f}, 32'd1);

    // ---- Test 4: fill both FIFOs, 17th write dropped ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      for (int t = 0; t < 40 && f_f; t++) tick();
      if (f_f) flag_fail("full_wait_timeout");
      write_byte(8'h10 + 8'(i), 1'b1);
    end
    for (int i = 0; i < 200; i++) tick();
    check("full_f_f", {31'd0, f_f}, 32'd1);
    check("full_e_f", {31'd0, e_f}, 32'd0);
    write_byte(8'hEE, 1'b0);
    check("full_after_drop_f_f", {31'd0, f_f}, 32'd1);
    drain(400, "full_drain_timeout");
    for (int i = 0; i < 30; i++) tick();
    check("full_end_e_f", {31'd0, e_f}, 32'd1);
    check("full_end_f_f", {31'd0, f_f}, 32'd0);
    check("full_end_out", {24'd0, output_data}, 32'h1F);

    // ---- Test 5: reads held on while writing ----
    r_e = 1'b1;
    write_byte(8'h6C, 1'b1);
    write_byte(8'h64, 1'b1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) flag_fail("conc_timeout");
    tick();
    r_e = 1'b0;
    check("conc_e_f", {31'd0, e_f}, 32'd1);
    check("conc_out", {24'd0, output_data}, 32'h64);

    // ---- Test 6: reset mid-frame discards the byte ----
    do_reset();
    write_byte(8'h55, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_e = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("midrst_e_f", {31'd0, e_f}, 32'd1);
    end
    r_e = 1'b0;
    check("midrst_out", {24'd0, output_data}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
